// File: rtl/voice_scan_mux.sv
// Snapshots 24 voice buses and streams them out one slot per valid/ready handshake,
// producing a per-frame unsigned sum of the snapshot for the mix/level path.
module voice_scan_mux #(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic [DATA_W-1:0] in9,
  input  logic [DATA_W-1:0] in10,
  input  logic [DATA_W-1:0] in11,
  input  logic [DATA_W-1:0] in12,
  input  logic [DATA_W-1:0] in13,
  input  logic [DATA_W-1:0] in14,
  input  logic [DATA_W-1:0] in15,
  input  logic [DATA_W-1:0] in16,
  input  logic [DATA_W-1:0] in17,
  input  logic [DATA_W-1:0] in18,
  input  logic [DATA_W-1:0] in19,
  input  logic [DATA_W-1:0] in20,
  input  logic [DATA_W-1:0] in21,
  input  logic [DATA_W-1:0] in22,
  input  logic [DATA_W-1:0] in23,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [DATA_W+4:0] mix_sum,
  output logic              mix_valid,
  output logic              busy
);

  localparam int SUM_W = DATA_W + 5;

  typedef enum logic [2:0] {IDLE, CAPTURE, SEND, DONE, GAP} state_t;

  state_t            state;
  logic [DATA_W-1:0] in_bus [24];
  logic [DATA_W-1:0] bank   [24];
  logic [4:0]        slot;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  acc_next;
  logic [7:0]        gap_cnt;

  assign in_bus = '{in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
                    in8,  in9,  in10, in11, in12, in13, in14, in15,
                    in16, in17, in18, in19, in20, in21, in22, in23};

  assign acc_next = acc + SUM_W'(out_data);

  // Snapshot bank needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      for (int k = 0; k < 24; k++) begin
        bank[k] <= in_bus[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      mix_sum   <= '0;
      slot      <= '0;
      acc       <= '0;
      gap_cnt   <= '0;
    end else begin
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          slot      <= '0;
          acc       <= '0;
          out_valid <= 1'b1;
          out_sel   <= '0;
          out_data  <= in_bus[0];
          out_first <= 1'b1;
          out_last  <= 1'b0;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            acc <= acc_next;
            if (slot == 5'd23) begin
              mix_sum   <= acc_next;
              mix_valid <= 1'b1;
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              state     <= DONE;
            end else begin
              slot      <= slot + 5'd1;
              out_sel   <= slot + 5'd1;
              out_data  <= bank[slot + 5'd1];
              out_first <= 1'b0;
              out_last  <= (slot == 5'd22);
            end
          end
        end
        DONE: begin
          if (IDLE_GAP > 0) begin
            gap_cnt <= 8'(IDLE_GAP - 1);
            state   <= GAP;
          end else begin
            state <= enable ? CAPTURE : IDLE;
            busy  <= enable;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= enable ? CAPTURE : IDLE;
            busy  <= enable;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scan_mux.sv
// Scoreboard bench for voice_scan_mux: frames of expected slots and sums are queued
// at stimulus time and consumed by independent monitors on the falling edge.
module tb_voice_scan_mux;

  localparam int DW   = 8;
  localparam int GAP3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          outReady = 1'b1;
  logic          rdy3 = 1'b1;
  logic [DW-1:0] vin [24];

  logic [DW-1:0] od, od3;
  logic [4:0]    os, os3;
  logic          ov, of, ol, mv, bz;
  logic          ov3, of3, ol3, mv3, bz3;
  logic [12:0]   ms, ms3;

  voice_scan_mux #(.DATA_W(DW), .IDLE_GAP(0)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in0(vin[0]),   .in1(vin[1]),   .in2(vin[2]),   .in3(vin[3]),
    .in4(vin[4]),   .in5(vin[5]),   .in6(vin[6]),   .in7(vin[7]),
    .in8(vin[8]),   .in9(vin[9]),   .in10(vin[10]), .in11(vin[11]),
    .in12(vin[12]), .in13(vin[13]), .in14(vin[14]), .in15(vin[15]),
    .in16(vin[16]), .in17(vin[17]), .in18(vin[18]), .in19(vin[19]),
    .in20(vin[20]), .in21(vin[21]), .in22(vin[22]), .in23(vin[23]),
    .out_data(od), .out_sel(os), .out_valid(ov), .out_ready(outReady),
    .out_first(of), .out_last(ol), .mix_sum(ms), .mix_valid(mv), .busy(bz)
  );

  voice_scan_mux #(.DATA_W(DW), .IDLE_GAP(GAP3)) dutGap (
    .clk(clk), .rst(rst), .enable(enable),
    .in0(vin[0]),   .in1(vin[1]),   .in2(vin[2]),   .in3(vin[3]),
    .in4(vin[4]),   .in5(vin[5]),   .in6(vin[6]),   .in7(vin[7]),
    .in8(vin[8]),   .in9(vin[9]),   .in10(vin[10]), .in11(vin[11]),
    .in12(vin[12]), .in13(vin[13]), .in14(vin[14]), .in15(vin[15]),
    .in16(vin[16]), .in17(vin[17]), .in18(vin[18]), .in19(vin[19]),
    .in20(vin[20]), .in21(vin[21]), .in22(vin[22]), .in23(vin[23]),
    .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(rdy3),
    .out_first(of3), .out_last(ol3), .mix_sum(ms3), .mix_valid(mv3), .busy(bz3)
  );

  typedef struct {int sel; int data; bit first; bit last;} slot_t;

  slot_t expQ[$];
  int    sumQ[$];
  int    firstCyc[$];
  int    lastCyc[$];
  int    gapLens[$];
  int    nChecks = 0;
  int    nPass = 0;
  int    cyc = 0;
  int    mixSeen = 0;
  int    readyMode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    $display("[TB] FAIL %s: got timeout, expected event within budget", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame is just the 24 bus values in order plus their plain sum.
  task automatic pushFrame();
    int s = 0;
    for (int k = 0; k < 24; k++) begin
      expQ.push_back('{sel: k, data: int'(vin[k]), first: (k == 0), last: (k == 23)});
      s += int'(vin[k]);
    end
    sumQ.push_back(s);
  endtask

  task automatic waitMix(input int target, input string name);
    int n = 0;
    while (mixSeen < target && n < 400) begin tick(); n++; end
    if (mixSeen < target) timeoutFail(name);
  endtask

  task automatic waitSel(input int sel, input string name);
    int n = 0;
    while (!(ov && int'(os) == sel) && n < 400) begin tick(); n++; end
    if (!(ov && int'(os) == sel)) timeoutFail(name);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((expQ.size() != 0 || sumQ.size() != 0 || bz) && n < 2000) begin tick(); n++; end
    if (expQ.size() != 0 || sumQ.size() != 0 || bz) timeoutFail(name);
  endtask

  // Runs n back-to-back frames, dropping enable when the last frame reaches dropSel.
  task automatic applyStimulus(input int n, input int dropSel);
    int base = mixSeen;
    repeat (n) pushFrame();
    enable = 1'b1;
    if (n > 1) waitMix(base + n - 1, "frames mix wait");
    waitSel(dropSel, "frames drop wait");
    enable = 1'b0;
    waitIdle("frames idle wait");
  endtask

  // Ready driver: 0 always high, 1 pattern 1,0,0,1, 2 held low, 3 random.
  initial begin
    bit pat[4];
    int ph = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: outReady = 1'b1;
        1: begin outReady = pat[ph % 4]; ph++; end
        2: outReady = 1'b0;
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor for the gapless instance.
  initial begin
    bit    prevStall = 1'b0;
    int    pSel = 0, pData = 0;
    bit    pFirst = 1'b0, pLast = 1'b0;
    slot_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stall valid", int'(ov), 1);
          checkOutput("stall sel", int'(os), pSel);
          checkOutput("stall data", int'(od), pData);
          checkOutput("stall first", int'(of), int'(pFirst));
          checkOutput("stall last", int'(ol), int'(pLast));
        end
        if (ov) checkOutput("sel range", int'(os < 5'd24), 1);
        if (ov && outReady) begin
          if (expQ.size() == 0) begin
            timeoutFail("unexpected slot (no expectation queued)");
          end else begin
            e = expQ.pop_front();
            checkOutput("slot sel", int'(os), e.sel);
            checkOutput("slot data", int'(od), e.data);
            checkOutput("slot first", int'(of), int'(e.first));
            checkOutput("slot last", int'(ol), int'(e.last));
          end
          if (of) firstCyc.push_back(cyc);
          if (ol) lastCyc.push_back(cyc);
        end
        if (mv) begin
          mixSeen++;
          if (sumQ.size() == 0) timeoutFail("unexpected mix_valid");
          else checkOutput("mix_sum", int'(ms), sumQ.pop_front());
        end
        prevStall = ov && !outReady;
        pSel = int'(os); pData = int'(od); pFirst = of; pLast = ol;
      end
    end
  end

  // Gap monitor: idle cycles between the mix pulse and the next valid slot.
  initial begin
    bit armed = 1'b0, allBusy = 1'b0;
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        armed = 1'b0;
      end else if (mv3) begin
        armed = 1'b1; cnt = 0; allBusy = 1'b1;
      end else if (armed) begin
        if (ov3) begin
          if (allBusy) gapLens.push_back(cnt);
          armed = 1'b0;
        end else begin
          cnt++;
          if (!bz3) allBusy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, mb;
    for (int k = 0; k < 24; k++) vin[k] = 8'(k + 1);
    repeat (3) tick();
    checkOutput("reset out_valid", int'(ov), 0);
    checkOutput("reset out_first", int'(of), 0);
    checkOutput("reset out_last", int'(ol), 0);
    checkOutput("reset mix_valid", int'(mv), 0);
    checkOutput("reset busy", int'(bz), 0);
    checkOutput("reset out_data", int'(od), 0);
    checkOutput("reset out_sel", int'(os), 0);
    checkOutput("reset mix_sum", int'(ms), 0);
    rst = 1'b0;
    tick();

    $display("[TB] ramp frames, ready high");
    firstCyc.delete(); lastCyc.delete();
    mb = mixSeen;
    pushFrame(); pushFrame();
    enable = 1'b1;
    lat = 0;
    while (!ov && lat < 10) begin tick(); lat++; end
    checkOutput("enable to first valid latency", lat, 2);
    waitMix(mb + 1, "ramp first frame");
    waitSel(10, "ramp slot 10");
    enable = 1'b0;
    waitIdle("ramp idle");
    repeat (3) tick();
    if (firstCyc.size() >= 2 && lastCyc.size() >= 1) begin
      checkOutput("frame period", firstCyc[1] - firstCyc[0], 26);
      checkOutput("slots back to back", lastCyc[0] - firstCyc[0], 23);
    end else timeoutFail("ramp first/last markers");
    checkOutput("ramp mix_sum held", int'(ms), 300);
    checkOutput("idle busy after drop", int'(bz), 0);
    checkOutput("idle out_valid after drop", int'(ov), 0);

    $display("[TB] ramp frames, ready 1,0,0,1");
    readyMode = 1;
    applyStimulus(2, 5);
    checkOutput("pattern mix_sum", int'(ms), 300);
    readyMode = 0;
    tick();

    $display("[TB] saturated inputs, change after capture");
    for (int k = 0; k < 24; k++) vin[k] = 8'hFF;
    pushFrame();
    enable = 1'b1;
    lat = 0;
    while (!(ov && of) && lat < 20) begin tick(); lat++; end
    if (!(ov && of)) timeoutFail("saturated first slot");
    tick(); tick();
    for (int k = 0; k < 24; k++) vin[k] = 8'h00;
    enable = 1'b0;
    waitIdle("saturated idle");
    checkOutput("saturated mix_sum", int'(ms), 6120);

    $display("[TB] gap instance with enable held");
    repeat (10) tick();
    gapLens.delete();
    for (int k = 0; k < 24; k++) vin[k] = 8'($urandom_range(0, 255));
    applyStimulus(4, 10);
    if (gapLens.size() == 0) timeoutFail("gap observation");
    // Three GAP cycles plus the CAPTURE cycle separate DONE from the next valid slot.
    foreach (gapLens[i]) checkOutput("gap idle cycles", gapLens[i], GAP3 + 1);

    $display("[TB] reset mid-frame");
    repeat (10) tick();
    pushFrame();
    enable = 1'b1;
    waitSel(12, "abort slot 12");
    rst = 1'b1;
    expQ.delete(); sumQ.delete();
    mb = mixSeen;
    tick();
    checkOutput("abort out_valid", int'(ov), 0);
    checkOutput("abort mix_valid", int'(mv), 0);
    checkOutput("abort mix_sum", int'(ms), 0);
    checkOutput("abort busy", int'(bz), 0);
    rst = 1'b0;
    pushFrame();
    waitSel(0, "restart slot 0");
    checkOutput("restart first", int'(of), 1);
    enable = 1'b0;
    waitIdle("restart idle");
    checkOutput("restart single mix pulse", mixSeen, mb + 1);

    $display("[TB] long backpressure at slot 0");
    readyMode = 2;
    tick(); tick();
    for (int k = 0; k < 24; k++) vin[k] = 8'($urandom_range(0, 255));
    pushFrame();
    mb = mixSeen;
    enable = 1'b1;
    waitSel(0, "hold slot 0");
    enable = 1'b0;
    repeat (100) tick();
    checkOutput("hold out_valid", int'(ov), 1);
    checkOutput("hold out_sel", int'(os), 0);
    checkOutput("hold out_first", int'(of), 1);
    checkOutput("hold no mix", mixSeen, mb);
    readyMode = 0;
    waitIdle("hold release idle");
    checkOutput("hold mix after release", mixSeen, mb + 1);

    $display("[TB] random inputs and ready");
    readyMode = 3;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 24; k++) vin[k] = 8'($urandom_range(0, 255));
      applyStimulus(2, int'($urandom_range(0, 23)));
      tick();
    end
    readyMode = 0;
    repeat (5) tick();
    checkOutput("leftover expectations", expQ.size() + sumQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
